// File: rtl/fptd_pkg.sv
// Shared types and constants for the turbo decoder iteration scheduler.
package fptd_pkg;

    localparam int unsigned DEF_MAX_ITER = 16;
    localparam int unsigned DEF_ET_RUNS  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ODD   = 3'd2,
        EVEN  = 3'd3,
        DONE  = 3'd4
    } fptd_state_e;

    // Registered Moore outputs of the scheduler
    typedef struct packed {
        logic ready;
        logic nclear;
        logic en_odd;
        logic en_even;
        logic busy;
        logic out_valid;
    } fptd_outs_t;

    // Counter width able to hold 0..max_iter
    function automatic int unsigned fptd_iter_w(input int unsigned max_iter);
        return $clog2(max_iter + 1);
    endfunction

    // Output pattern for a given state
    function automatic fptd_outs_t fptd_decode(input fptd_state_e st);
        fptd_outs_t o;
        o = '{ready: 1'b0, nclear: 1'b1, en_odd: 1'b0, en_even: 1'b0,
              busy: 1'b0, out_valid: 1'b0};
        case (st)
            IDLE:    o.ready     = 1'b1;
            CLEAR:   begin o.nclear  = 1'b0; o.busy = 1'b1; end
            ODD:     begin o.en_odd  = 1'b1; o.busy = 1'b1; end
            EVEN:    begin o.en_even = 1'b1; o.busy = 1'b1; end
            DONE:    o.out_valid = 1'b1;
            default: o.ready     = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fptd_iter_ctrl_if.sv
// Control/handshake bundle between frame loader, scheduler and downstream.
interface fptd_iter_ctrl_if #(
    parameter int unsigned ITER_W = fptd_pkg::fptd_iter_w(fptd_pkg::DEF_MAX_ITER)
) ();
    import fptd_pkg::*;

    logic              Start;
    logic              Ready;
    logic [ITER_W-1:0] CfgIter;
    logic              CfgEtEn;
    logic              Abort;
    logic              Stable;
    logic              nClear;
    logic              EnOdd;
    logic              EnEven;
    logic              Busy;
    logic [ITER_W-1:0] IterCount;
    logic              EarlyStop;
    logic              OutValid;
    logic              OutReady;

    // Loader / downstream side
    modport master (
        output Start, CfgIter, CfgEtEn, Abort, Stable, OutReady,
        input  Ready, nClear, EnOdd, EnEven, Busy, IterCount, EarlyStop, OutValid
    );

    // Scheduler side
    modport slave (
        input  Start, CfgIter, CfgEtEn, Abort, Stable, OutReady,
        output Ready, nClear, EnOdd, EnEven, Busy, IterCount, EarlyStop, OutValid
    );

endinterface

// File: rtl/fptd_et_detect.sv
// Saturating counter of consecutive stable iterations for early termination.
module fptd_et_detect #(
    parameter int unsigned ET_RUNS = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clr,
    input  logic step,
    input  logic stable,
    output logic hit_c
);
    localparam int unsigned    RUN_W   = $clog2(ET_RUNS + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(ET_RUNS);

    logic [RUN_W-1:0] run;

    // Count stable iterations, restart on any unstable one
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            run <= '0;
        end else if (clr) begin
            run <= '0;
        end else if (step) begin
            if (!stable)
                run <= '0;
            else if (run != RUN_MAX)
                run <= run + RUN_W'(1);
        end
    end

    // Threshold reached counting the iteration being closed now
    assign hit_c = stable && ((32'(run) + 32'd1) >= ET_RUNS);

endmodule

// File: rtl/fptd_iter_ctrl.sv
// Iteration scheduler for the fully parallel turbo decoder PE array.
module fptd_iter_ctrl import fptd_pkg::*; #(
    parameter int unsigned MAX_ITER = DEF_MAX_ITER,
    parameter int unsigned ET_RUNS  = DEF_ET_RUNS
) (
    input logic             Clock,
    input logic             Reset,
    fptd_iter_ctrl_if.slave bus
);
    localparam int unsigned       ITER_W  = fptd_iter_w(MAX_ITER);
    localparam logic [ITER_W-1:0] LIM_MAX = ITER_W'(MAX_ITER);

    fptd_state_e       state;
    fptd_outs_t        outs;
    logic [ITER_W-1:0] limit;
    logic [ITER_W-1:0] iter_cnt;
    logic              et_en;
    logic              early;

    logic [ITER_W-1:0] cfg_lim_c;
    logic [ITER_W-1:0] iter_inc_c;
    logic              last_iter_c;
    logic              accept_c;
    logic              et_step_c;
    logic              et_hit_c;

    // Clamp the requested limit into 1..MAX_ITER
    always_comb begin
        cfg_lim_c = bus.CfgIter;
        if (bus.CfgIter == '0)
            cfg_lim_c = ITER_W'(1);
        else if (32'(bus.CfgIter) > MAX_ITER)
            cfg_lim_c = LIM_MAX;
    end

    // Iteration bookkeeping and handshake qualifiers
    always_comb begin
        iter_inc_c  = iter_cnt + ITER_W'(1);
        last_iter_c = (iter_inc_c == limit);
        accept_c    = (state == IDLE) && bus.Start && !bus.Abort;
        et_step_c   = (state == EVEN) && !bus.Abort;
    end

    fptd_et_detect #(
        .ET_RUNS (ET_RUNS)
    ) u_et (
        .Clock  (Clock),
        .Reset  (Reset),
        .clr    (accept_c),
        .step   (et_step_c),
        .stable (bus.Stable),
        .hit_c  (et_hit_c)
    );

    // Scheduler FSM with registered outputs, counter and config latches
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            outs     <= fptd_decode(IDLE);
            limit    <= ITER_W'(1);
            iter_cnt <= '0;
            et_en    <= 1'b0;
            early    <= 1'b0;
        end else if (bus.Abort && (state != IDLE)) begin
            state <= IDLE;
            outs  <= fptd_decode(IDLE);
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state    <= CLEAR;
                        outs     <= fptd_decode(CLEAR);
                        limit    <= cfg_lim_c;
                        et_en    <= bus.CfgEtEn;
                        iter_cnt <= '0;
                        early    <= 1'b0;
                    end
                end
                CLEAR: begin
                    state <= ODD;
                    outs  <= fptd_decode(ODD);
                end
                ODD: begin
                    state <= EVEN;
                    outs  <= fptd_decode(EVEN);
                end
                EVEN: begin
                    iter_cnt <= iter_inc_c;
                    if (last_iter_c) begin
                        state <= DONE;
                        outs  <= fptd_decode(DONE);
                        early <= 1'b0;
                    end else if (et_en && et_hit_c) begin
                        state <= DONE;
                        outs  <= fptd_decode(DONE);
                        early <= 1'b1;
                    end else begin
                        state <= ODD;
                        outs  <= fptd_decode(ODD);
                    end
                end
                DONE: begin
                    if (bus.OutReady) begin
                        state <= IDLE;
                        outs  <= fptd_decode(IDLE);
                    end
                end
                default: begin
                    state <= IDLE;
                    outs  <= fptd_decode(IDLE);
                end
            endcase
        end
    end

    // Drive the bus from the registered outputs
    assign bus.Ready     = outs.ready;
    assign bus.nClear    = outs.nclear;
    assign bus.EnOdd     = outs.en_odd;
    assign bus.EnEven    = outs.en_even;
    assign bus.Busy      = outs.busy;
    assign bus.OutValid  = outs.out_valid;
    assign bus.IterCount = iter_cnt;
    assign bus.EarlyStop = early;

endmodule

// File: tb/tb_fptd_iter_ctrl.sv
// Randomized self-checking bench for the iteration scheduler.
module tb_fptd_iter_ctrl;
    import fptd_pkg::*;

    localparam int MAXI = 16;
    localparam int ETR  = 2;
    localparam int unsigned IW = fptd_iter_w(MAXI);

    logic Clock;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    fptd_iter_ctrl_if #(.ITER_W(IW)) bus ();

    fptd_iter_ctrl #(.MAX_ITER(MAXI), .ET_RUNS(ETR)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Reference: iterations run and early-stop flag from the frame rules
    function automatic void model(input int cfg, input bit et, input logic [16:0] stab,
                                  output int n, output bit early);
        int lim;
        int run;
        bit fin;
        lim   = (cfg == 0) ? 1 : ((cfg > MAXI) ? MAXI : cfg);
        run   = 0;
        n     = lim;
        early = 1'b0;
        fin   = 1'b0;
        for (int i = 1; i <= lim; i++) begin
            if (!fin) begin
                run = stab[i] ? ((run + 1 > ETR) ? ETR : run + 1) : 0;
                if (i == lim) begin
                    n = i; early = 1'b0; fin = 1'b1;
                end else if (et && run >= ETR) begin
                    n = i; early = 1'b1; fin = 1'b1;
                end
            end
        end
    endfunction

    task automatic chk_reset_vals(input string nm);
        chk({nm, ":ready"},  32'(bus.Ready), 1);
        chk({nm, ":nclear"}, 32'(bus.nClear), 1);
        chk({nm, ":enodd"},  32'(bus.EnOdd), 0);
        chk({nm, ":eneven"}, 32'(bus.EnEven), 0);
        chk({nm, ":busy"},   32'(bus.Busy), 0);
        chk({nm, ":oval"},   32'(bus.OutValid), 0);
        chk({nm, ":iter"},   32'(bus.IterCount), 0);
        chk({nm, ":early"},  32'(bus.EarlyStop), 0);
    endtask

    // One frame: m counts clock edges after the accepting edge
    task automatic run_frame(input int cfg, input bit et, input logic [16:0] stab,
                             input int hold, input int abort_m, input string nm);
        int n;
        bit early;
        int last;
        bit aborted;
        int ecnt;
        model(cfg, et, stab, n, early);
        last    = 2 * n + 1 + hold;
        aborted = 1'b0;
        @(negedge Clock);
        chk({nm, ":ready_pre"}, 32'(bus.Ready), 1);
        bus.Start    = 1'b1;
        bus.CfgIter  = IW'(cfg);
        bus.CfgEtEn  = et;
        bus.Abort    = 1'b0;
        bus.OutReady = 1'b0;
        for (int m = 0; m <= last && !aborted; m++) begin
            @(posedge Clock);
            #1;
            if (abort_m >= 0 && m == abort_m + 1) begin
                aborted = 1'b1;
                chk({nm, ":ab_ready"},  32'(bus.Ready), 1);
                chk({nm, ":ab_busy"},   32'(bus.Busy), 0);
                chk({nm, ":ab_oval"},   32'(bus.OutValid), 0);
                chk({nm, ":ab_enodd"},  32'(bus.EnOdd), 0);
                chk({nm, ":ab_eneven"}, 32'(bus.EnEven), 0);
                chk({nm, ":ab_nclear"}, 32'(bus.nClear), 1);
            end else begin
                ecnt = (m == 0) ? 0 : (m - 1) / 2;
                if (ecnt > n) ecnt = n;
                chk({nm, ":nclear"}, 32'(bus.nClear), (m != 0) ? 1 : 0);
                chk({nm, ":enodd"},  32'(bus.EnOdd), (m % 2 == 1 && m < 2 * n) ? 1 : 0);
                chk({nm, ":eneven"}, 32'(bus.EnEven), (m % 2 == 0 && m >= 2 && m <= 2 * n) ? 1 : 0);
                chk({nm, ":busy"},   32'(bus.Busy), (m <= 2 * n) ? 1 : 0);
                chk({nm, ":ready"},  32'(bus.Ready), 0);
                chk({nm, ":oval"},   32'(bus.OutValid), (m >= 2 * n + 1) ? 1 : 0);
                chk({nm, ":iter"},   32'(bus.IterCount), ecnt);
                if (m >= 2 * n + 1)
                    chk({nm, ":early"}, 32'(bus.EarlyStop), early ? 1 : 0);
            end
            @(negedge Clock);
            if (aborted || m == last) begin
                bus.Start = 1'b0;
                bus.Abort = 1'b0;
            end else begin
                bus.Start   = 1'($urandom);
                bus.CfgIter = IW'($urandom);
                bus.CfgEtEn = 1'($urandom);
                bus.Abort   = (m == abort_m) ? 1'b1 : 1'b0;
            end
            bus.Stable   = (m % 2 == 0 && m >= 2 && m <= 2 * n) ? stab[m / 2] : 1'($urandom);
            bus.OutReady = (m >= 2 * n + 1) ? ((m == last) ? 1'b1 : 1'b0) : 1'($urandom);
        end
        if (!aborted) begin
            @(posedge Clock);
            #1;
            chk({nm, ":end_ready"}, 32'(bus.Ready), 1);
            chk({nm, ":end_oval"},  32'(bus.OutValid), 0);
            chk({nm, ":end_busy"},  32'(bus.Busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc;
        int rn;
        bit re;
        logic [16:0] rs;
        int ab;
        Reset        = 1'b1;
        bus.Start    = 1'b0;
        bus.CfgIter  = '0;
        bus.CfgEtEn  = 1'b0;
        bus.Abort    = 1'b0;
        bus.Stable   = 1'b0;
        bus.OutReady = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk_reset_vals("rst");
        @(negedge Clock);
        Reset = 1'b0;

        run_frame(4,  1'b0, 17'h0,     0, -1, "lim4");
        run_frame(8,  1'b1, 17'h1FFF8, 0, -1, "et4");
        run_frame(8,  1'b1, 17'h1FFE8, 0, -1, "et_drop");
        run_frame(0,  1'b0, 17'h0,     0, -1, "cfg0");
        run_frame(31, 1'b0, 17'h1FFFF, 0, -1, "cfg31");
        run_frame(8,  1'b1, 17'h0,     0,  6, "abort3");
        run_frame(3,  1'b1, 17'h1FFFF, 5, -1, "hold5");
        run_frame(2,  1'b1, 17'h1FFFF, 0, -1, "limprio");
        run_frame(5,  1'b0, 17'h0,     0, -1, "b2b");

        // Asynchronous reset while in ODD
        @(negedge Clock);
        bus.Start   = 1'b1;
        bus.CfgIter = IW'(4);
        bus.CfgEtEn = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        bus.Start = 1'b0;
        @(posedge Clock);
        #1;
        chk("rstodd:enodd_pre", 32'(bus.EnOdd), 1);
        #2;
        Reset = 1'b1;
        #1;
        chk_reset_vals("rstodd");
        @(negedge Clock);
        Reset = 1'b0;
        run_frame(4, 1'b0, 17'h0, 0, -1, "post_rst");

        // Start with Abort in IDLE stays idle
        @(negedge Clock);
        bus.Start = 1'b1;
        bus.Abort = 1'b1;
        @(posedge Clock);
        #1;
        chk("idle_ab:ready", 32'(bus.Ready), 1);
        chk("idle_ab:busy",  32'(bus.Busy), 0);
        chk("idle_ab:nclr",  32'(bus.nClear), 1);
        @(negedge Clock);
        bus.Start = 1'b0;
        bus.Abort = 1'b0;

        for (int f = 0; f < 30; f++) begin
            rc = $urandom_range(0, 31);
            re = 1'($urandom);
            rs = 17'($urandom);
            model(rc, re, rs, rn, re);
            re = 1'($urandom);
            model(rc, re, rs, rn, rs[0]);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2 * rn) : -1;
            run_frame(rc, re, rs, $urandom_range(0, 3), ab, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fptd_iter_ctrl.md
# fptd_iter_ctrl

Iteration scheduler for the fully parallel turbo decoder core. It sequences the odd/even-indexed processing-element registers, including the extrinsic stage registers (Enable/nClear), across decoding iterations. It counts iterations against a per-frame limit and stops early once hard decisions are stable. The finished frame is presented downstream through a valid/ready handshake. It sits between the frame loader and the PE array, one instance per decoder core.

## Interface
- MAX_ITER, 16, largest supported iteration limit; sets counter width ITER_W = $clog2(MAX_ITER+1)
- ET_RUNS, 2, consecutive stable iterations required for early termination (≥1)
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  frame loaded, begin decoding; accepted only when Ready=1
- Ready  out  1  controller idle, Start will be accepted
- CfgIter  in  ITER_W  iteration limit, sampled on accepted Start; 0 treated as 1; values >MAX_ITER clamp to MAX_ITER
- CfgEtEn  in  1  early-termination enable, sampled on accepted Start
- Abort  in  1  drop current frame, return to idle
- Stable  in  1  hard decisions unchanged vs previous iteration; sampled only in EVEN state
- nClear  out  1  active-low synchronous clear to PE registers
- EnOdd  out  1  enable for odd-indexed PE registers
- EnEven  out  1  enable for even-indexed PE registers
- Busy  out  1  frame in progress (CLEAR, ODD, EVEN)
- IterCount  out  ITER_W  completed iterations of current/last frame
- EarlyStop  out  1  last frame ended by early termination (valid with OutValid)
- OutValid  out  1  decoded frame available
- OutReady  in  1  downstream accepts frame

## Operation
- States: IDLE, CLEAR, ODD, EVEN, DONE. Moore outputs decoded from registered state.
- IDLE: Ready=1. Start → latch CfgIter (clamped), CfgEtEn; IterCount←0; run counter←0; → CLEAR.
- CLEAR: nClear=0 for exactly one cycle → ODD.
- ODD: EnOdd=1 for one cycle → EVEN.
- EVEN: EnEven=1 for one cycle. IterCount←IterCount+1. Run counter←Stable ? run+1 (saturating at ET_RUNS) : 0.
- Exit from EVEN: if IterCount+1 == limit → DONE, EarlyStop←0. Else if CfgEtEn and (run+Stable) reaches ET_RUNS → DONE, EarlyStop←1. Else → ODD. Limit takes priority when both conditions hold: EarlyStop=0.
- DONE: OutValid=1, held with IterCount/EarlyStop stable until OutReady=1. OutValid∧OutReady → IDLE.
- Abort (any non-IDLE state) → IDLE next cycle, no OutValid. IterCount keeps its value. Abort has priority over all other transitions.
- Start outside IDLE is ignored. Start and Abort together in IDLE: Abort wins, stay IDLE.
- Only one of nClear=0, EnOdd, EnEven active in any cycle.

## Timing
- Reset values: state=IDLE, Ready=1, nClear=1, EnOdd=0, EnEven=0, Busy=0, OutValid=0, IterCount=0, EarlyStop=0.
- Start accepted at edge k: CLEAR in cycle k+1, ODD k+2, EVEN k+3.
- Limit N, no early stop: OutValid first high in cycle k+2+2N.
- Early stop after iteration i: OutValid in cycle k+2+2i.
- Back-to-back frames: OutReady high in DONE → IDLE next cycle. Next Start is accepted there, giving a minimum of one idle cycle between frames.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). PE state is not cleared by Reset; the next frame's CLEAR handles it.
- IterCount never exceeds MAX_ITER; no wrap.

## Structure
- Package fptd_pkg: state enum typedef (IDLE, CLEAR, ODD, EVEN, DONE), ITER_W derivation function, default MAX_ITER/ET_RUNS constants.
- One sub-module fptd_et_detect: saturating stable-run counter with clear/step inputs and a reached-threshold output, parameterised by ET_RUNS.
- FSM, iteration counter and config latches live in the top module.

## Test plan
- Reset, then Start with CfgIter=4, CfgEtEn=0 → nClear low 1 cycle, then EnOdd/EnEven alternate 4 times each, OutValid at start+10, IterCount=4, EarlyStop=0.
- CfgIter=8, CfgEtEn=1, ET_RUNS=2, Stable=1 from iteration 3 onward → DONE after iteration 4, IterCount=4, EarlyStop=1. Repeat with Stable dropping to 0 at iteration 4 → run counter resets.
- CfgIter=0 → exactly one iteration, IterCount=1. CfgIter=31 with MAX_ITER=16 → 16 iterations.
- Abort asserted during third EVEN → IDLE next cycle, Ready=1, OutValid never asserts. Start during Busy is ignored, with no change in schedule.
- OutReady held low 5 cycles in DONE → OutValid, IterCount, EarlyStop stable; OutReady=1 → IDLE; Start in that IDLE cycle is accepted.
- Reset asserted mid-ODD → outputs at reset values asynchronously. A fresh Start after deassertion runs a full frame normally.
